// File: rtl/circuito_exp3_ativ2_dp.sv
// -----------------------------------------------------------------------------
// circuito_exp3_ativ2_dp
// Datapath for Experiment 3. It contains:
//   - a 4-bit up-counter with asynchronous clear, synchronous load and count
//     enable
//   - an unsigned magnitude comparator between the count and the switches
//   - a hex 7-segment decoder (active-low, {g,f,e,d,c,b,a}) showing the count
// The counter register is the only state. Every output is a combinational
// function of that register and of the switches, so no output adds latency.
// -----------------------------------------------------------------------------
module circuito_exp3_ativ2_dp (
    input  logic       clock,
    input  logic       zera,
    input  logic       carrega,
    input  logic       conta,
    input  logic [3:0] chaves,
    output logic       menor,
    output logic       maior,
    output logic       igual,
    output logic       fim,
    output logic [3:0] db_contagem,
    output logic [6:0] display
);

    localparam logic [3:0] COUNT_MAX = 4'hF;

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Next-count selection: load has priority over increment; otherwise hold.
    // NOTE: always_comb assigns a default first, so every path drives count_d
    // and no latch can be inferred.
    always_comb begin
        count_d = count_q;
        if (carrega) begin
            count_d = chaves;
        end else if (conta) begin
            count_d = count_q + 4'd1;   // wraps naturally 15 -> 0
        end
    end

    // Counter register: zera clears it immediately, independent of the clock.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its pre-edge value.
    always_ff @(posedge clock or posedge zera) begin
        if (zera) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Unsigned magnitude compare. Exactly one flag is ever high.
    always_comb begin
        menor = (count_q <  chaves);
        maior = (count_q >  chaves);
        igual = (count_q == chaves);
    end

    // Terminal count and debug view of the register.
    always_comb begin
        fim         = (count_q == COUNT_MAX);
        db_contagem = count_q;
    end

    // Hex to 7-segment decode. The output is active-low, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        display = 7'b1111111;
        unique case (count_q)
            4'h0: display = 7'b1000000;
            4'h1: display = 7'b1111001;
            4'h2: display = 7'b0100100;
            4'h3: display = 7'b0110000;
            4'h4: display = 7'b0011001;
            4'h5: display = 7'b0010010;
            4'h6: display = 7'b0000010;
            4'h7: display = 7'b1111000;
            4'h8: display = 7'b0000000;
            4'h9: display = 7'b0010000;
            4'hA: display = 7'b0001000;
            4'hB: display = 7'b0000011;
            4'hC: display = 7'b1000110;
            4'hD: display = 7'b0100001;
            4'hE: display = 7'b0000110;
            4'hF: display = 7'b0001110;
            default: display = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_circuito_exp3_ativ2_dp.sv
// -----------------------------------------------------------------------------
// Testbench for circuito_exp3_ativ2_dp. It applies directed vectors whose
// expected values are worked out by hand. The clock runs freely. Inputs change
// on the falling edge and outputs are read away from the rising edge.
// -----------------------------------------------------------------------------
module tb_circuito_exp3_ativ2_dp;

    logic       clock = 1'b0;
    logic       zera;
    logic       carrega;
    logic       conta;
    logic [3:0] chaves;
    logic       menor;
    logic       maior;
    logic       igual;
    logic       fim;
    logic [3:0] db_contagem;
    logic [6:0] display;

    int n_vectors = 0;
    int n_errors  = 0;

    // Expected segment patterns, {g,f,e,d,c,b,a}, active-low.
    logic [6:0] seg_table [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    circuito_exp3_ativ2_dp dut (
        .clock       (clock),
        .zera        (zera),
        .carrega     (carrega),
        .conta       (conta),
        .chaves      (chaves),
        .menor       (menor),
        .maior       (maior),
        .igual       (igual),
        .fim         (fim),
        .db_contagem (db_contagem),
        .display     (display)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] observed,
                         input logic [7:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    // Checks the three compare flags together, ordered {menor, maior, igual}.
    task automatic check_cmp(input string tag, input logic [2:0] expected);
        check(tag, {5'b0, menor, maior, igual}, {5'b0, expected});
    endtask

    initial begin
        zera    = 1'b0;
        carrega = 1'b0;
        conta   = 1'b0;
        chaves  = 4'd0;

        // Asynchronous reset applied between edges.
        #2;
        zera = 1'b1;
        #1;
        check("rst_count", {4'b0, db_contagem}, 8'd0);
        check_cmp("rst_cmp", 3'b001);
        check("rst_fim", {7'b0, fim}, 8'd0);
        check("rst_display", {1'b0, display}, 8'b01000000);

        // Comparator follows chaves without any clock edge.
        @(negedge clock);
        zera   = 1'b0;
        chaves = 4'd1;
        #1;
        check_cmp("cmp_no_clk", 3'b100);
        check("cmp_no_clk_q", {4'b0, db_contagem}, 8'd0);

        // Counting.
        conta = 1'b1;
        @(negedge clock);
        check("count_1", {4'b0, db_contagem}, 8'd1);
        check_cmp("count_1_cmp", 3'b001);
        chaves = 4'd2;
        repeat (2) @(negedge clock);
        check("count_3", {4'b0, db_contagem}, 8'd3);
        check_cmp("count_3_cmp", 3'b010);
        check("count_3_display", {1'b0, display}, 8'b00110000);

        // Long run up to the terminal count, then wrap.
        chaves = 4'd6;
        repeat (11) @(negedge clock);
        check("count_14", {4'b0, db_contagem}, 8'd14);
        check_cmp("count_14_cmp", 3'b010);
        check("count_14_fim", {7'b0, fim}, 8'd0);
        @(negedge clock);
        check("count_15", {4'b0, db_contagem}, 8'd15);
        check("count_15_fim", {7'b0, fim}, 8'd1);
        check("count_15_display", {1'b0, display}, 8'd14);
        @(negedge clock);
        check("wrap_0", {4'b0, db_contagem}, 8'd0);
        check("wrap_fim", {7'b0, fim}, 8'd0);
        check_cmp("wrap_cmp", 3'b100);

        // Load has priority over count.
        chaves  = 4'd9;
        carrega = 1'b1;
        conta   = 1'b1;
        @(negedge clock);
        check("load_9", {4'b0, db_contagem}, 8'd9);
        check_cmp("load_9_cmp", 3'b001);
        carrega = 1'b0;
        conta   = 1'b0;
        repeat (3) @(negedge clock);
        check("hold_9", {4'b0, db_contagem}, 8'd9);

        // Asynchronous reset in the middle of operation.
        #2;
        zera = 1'b1;
        #1;
        check("async_clear", {4'b0, db_contagem}, 8'd0);
        @(negedge clock);
        check("clear_held", {4'b0, db_contagem}, 8'd0);
        zera  = 1'b0;
        conta = 1'b1;
        @(negedge clock);
        check("after_clear_1", {4'b0, db_contagem}, 8'd1);
        conta = 1'b0;

        // Decoder and comparator sweep: load each value, then compare it with 7.
        for (int v = 0; v < 16; v++) begin
            chaves  = 4'(v);
            carrega = 1'b1;
            @(negedge clock);
            carrega = 1'b0;
            chaves  = 4'd7;
            #1;
            check($sformatf("sweep_q_%0d", v), {4'b0, db_contagem}, 8'(v));
            check($sformatf("sweep_seg_%0d", v), {1'b0, display}, {1'b0, seg_table[v]});
            check_cmp($sformatf("sweep_cmp_%0d", v),
                      {(v < 7) ? 1'b1 : 1'b0, (v > 7) ? 1'b1 : 1'b0, (v == 7) ? 1'b1 : 1'b0});
            check($sformatf("sweep_fim_%0d", v), {7'b0, fim}, (v == 15) ? 8'd1 : 8'd0);
            @(negedge clock);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_errors);
        $finish;
    end

endmodule

// File: doc/circuito_exp3_ativ2_dp.md
Name: circuito_exp3_ativ2_dp

Overview:
Simple datapath for Experiment 3. A 4-bit up-counter has asynchronous clear, synchronous parallel load from switches and a count enable. A 4-bit magnitude comparator compares the counter value against the switch value. A hex 7-segment decoder drives a display with the count. All internal state is exposed for debug. It sits under the experiment top level, directly wired to board switches, LEDs and one HEX display.

Parameters:
None. All widths are fixed: 4-bit counter and switches, 7-bit display.

Ports:
clock  input  1  system clock; rising-edge active
zera  input  1  reset; asynchronous, active-high; clears the counter to 0
carrega  input  1  synchronous parallel load enable, active-high; loads chaves into the counter
conta  input  1  synchronous count enable, active-high; increments the counter
chaves  input  4  switch value; load data and comparator operand B
menor  output  1  1 when count < chaves (unsigned)
maior  output  1  1 when count > chaves (unsigned)
igual  output  1  1 when count == chaves
fim  output  1  terminal count; 1 when count == 4'hF
db_contagem  output  4  current counter value (debug)
display  output  7  7-segment pattern of db_contagem; bit order {g,f,e,d,c,b,a}; active-low

Behaviour:
- Counter register Q[3:0] is the only state.
- zera=1 forces Q=0 immediately, independent of clock, and holds it while asserted. This overrides carrega and conta.
- On each rising clock edge with zera=0, in priority order:
  - carrega=1: Q <= chaves.
  - else conta=1: Q <= Q+1, wrapping modulo 16 (15 -> 0).
  - else: Q holds.
- Simultaneous carrega and conta: the load wins and no increment occurs in that cycle.
- Reset mid-count: zera asserted between edges clears Q at once. The first edge after zera deasserts acts on Q=0.
- Comparator is purely combinational on Q and chaves; unsigned 4-bit compare.
  - Exactly one of menor/maior/igual is 1 at all times.
  - Outputs follow a chaves change with no clock needed.
- fim = (Q==15), combinational, not gated by conta.
- db_contagem = Q, combinational.
- display is a combinational decode of Q, active-low, order gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset values (zera=1): db_contagem=0, fim=0, display=1000000. Comparator outputs reflect 0 vs chaves; with chaves=0: igual=1, menor=0, maior=0.
- No pipeline latency on outputs. Counter updates take effect one edge after the enable is sampled.

Test Plan:
- Reset: conta=0, carrega=0, chaves=0, pulse zera=1 (no clock edge needed) -> db_contagem=0, igual=1, fim=0, display=1000000.
- Compare without clock: from Q=0, set chaves=1 -> menor=1, igual=0, maior=0 with no clock edge.
- Count: zera=0, conta=1, one edge -> Q=1, igual=1 (chaves=1). Then set chaves=2 and apply two more edges -> Q=3, maior=1, display=0110000.
- Long run: chaves=6, conta=1, 11 edges from Q=3 -> Q=14, maior=1, fim=0. One further edge -> Q=15, fim=1, display=0001110 (decimal 14). Next edge -> Q=0, fim=0.
- Load: chaves=9, carrega=1 and conta=1 together, one edge -> Q=9 (load priority), igual=1. Then carrega=0, conta=0, several edges -> Q stays 9.
- Async reset mid-operation: Q=9, assert zera between clock edges -> Q=0 immediately. Deassert zera, conta=1, one edge -> Q=1.
